// File: rtl/shared_ram_arbiter.sv
// ---------------------------------------------------------------------------
// shared_ram_arbiter
//
// Shares one single-port RAM between NUM_REQ requesters. Each transaction is
// served in full before the next one is chosen. A requester holds req high
// until it sees its one-cycle done pulse. Addresses whose upper nibble is not
// 4'h0 fall outside the RAM region. They finish at once with err=1 and never
// touch the RAM.
//
// Configuration macro:
//   SHARED_RAM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                                 undefined -> round-robin starting after the
//                                              most recent winner (default)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [NUM_REQ]         request level per requester
//   req_we     in   [NUM_REQ]         1 = write, 0 = read
//   req_addr   in   [NUM_REQ*ADDR_W]  packed addresses, requester i at i*ADDR_W
//   req_wdata  in   [NUM_REQ*DATA_W]  packed write data
//   done       out  [NUM_REQ]         one-hot completion pulse
//   err        out                    out-of-region flag, valid with done
//   rdata      out  [DATA_W]          read data, valid with done on reads
//   mem_en     out                    RAM strobe
//   mem_we     out                    RAM write enable
//   mem_addr   out  [ADDR_W]          RAM address
//   mem_wdata  out  [DATA_W]          RAM write data
//   mem_rdata  in   [DATA_W]          RAM read data, RD_LATENCY cycles after mem_en
// ---------------------------------------------------------------------------
module shared_ram_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          done,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // S_IDLE   | sample req, pick a winner, latch its command
    // S_ACCESS | mem_en high for one cycle
    // S_WAIT   | read latency countdown, capture mem_rdata when count is 1
    // S_RESP   | done[winner] pulse with err
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 4;

    state_t             state;
    logic [IDX_W-1:0]   win_idx;
    logic               lat_we;
    logic [CNT_W-1:0]   lat_cnt;

    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_in_region;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef SHARED_RAM_ARB_FIXED_PRIO_EN
    // The loop runs from the top index down, so the lowest active index
    // assigns last and wins.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0]   last;
    logic [IDX_W:0]     cand;

    // The search covers last+1 .. last+NUM_REQ. Each candidate index wraps
    // back into range by one subtraction. A true modulo is not needed here.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!sel_any && req[cand[IDX_W-1:0]]) begin
                sel_idx = cand[IDX_W-1:0];
                sel_any = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_in_region = (sel_addr[ADDR_W-1 -: 4] == 4'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            win_idx   <= '0;
            lat_we    <= 1'b0;
            lat_cnt   <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifndef SHARED_RAM_ARB_FIXED_PRIO_EN
            last      <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    err  <= 1'b0;
                    if (sel_any) begin
                        win_idx   <= sel_idx;
                        lat_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
`ifndef SHARED_RAM_ARB_FIXED_PRIO_EN
                        last      <= sel_idx;
`endif
                        if (sel_in_region) begin
                            mem_en <= 1'b1;
                            mem_we <= sel_we;
                            state  <= S_ACCESS;
                        end else begin
                            // Out-of-region: answer in the next cycle, RAM untouched.
                            done  <= onehot(sel_idx);
                            err   <= 1'b1;
                            state <= S_RESP;
                        end
                    end
                end

                S_ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (lat_we) begin
                        done  <= onehot(win_idx);
                        state <= S_RESP;
                    end else begin
                        lat_cnt <= CNT_W'(RD_LATENCY);
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (lat_cnt == CNT_W'(1)) begin
                        rdata <= mem_rdata;
                        done  <= onehot(win_idx);
                        state <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end

                S_RESP: begin
                    done  <= '0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
module tb_shared_ram_arbiter;

    localparam int NR = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     done;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    shared_ram_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LATENCY(RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: write on the mem_en edge, read data delayed through RL stages.
    logic [DW-1:0] ram     [256];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) rd_pipe[0]    <= ram[mem_addr];
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle. Returns at the negedge of the
    // IDLE cycle that follows the done pulse.
    task automatic run_txn(input int r, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, output int lat,
                           output logic [NR-1:0] dv, output logic ev,
                           output logic [7:0] rv, output int en_cnt);
        req_we[r]             = we;
        req_addr[r*AW +: AW]  = addr;
        req_wdata[r*DW +: DW] = wdata;
        req                   = '0;
        req[r]                = 1'b1;
        lat    = -1;
        en_cnt = 0;
        dv     = '0;
        ev     = 1'b0;
        rv     = '0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (done != '0) begin
                lat = c;
                dv  = done;
                ev  = err;
                rv  = rdata;
                req = '0;
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    typedef struct {
        int         r;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          lat;
        int          en_cnt;
        logic [NR-1:0] dv;
        logic        ev;
        logic [7:0]  rv;
        int          grants;
        int          g_idx [6];
        int          dlat;

        //           r  we    addr   wdata  rdata  err   lat
        vecs[0]  = '{0, 1'b1, 8'h05, 8'hA5, 8'h00, 1'b0, 2};
        vecs[1]  = '{2, 1'b1, 8'h06, 8'h66, 8'h00, 1'b0, 2};
        vecs[2]  = '{1, 1'b0, 8'h05, 8'h00, 8'hA5, 1'b0, 4};
        vecs[3]  = '{0, 1'b1, 8'h0A, 8'h3C, 8'hA5, 1'b0, 2};
        vecs[4]  = '{0, 1'b0, 8'h0A, 8'h00, 8'h3C, 1'b0, 4};
        vecs[5]  = '{2, 1'b0, 8'h25, 8'h00, 8'h3C, 1'b1, 1};
        vecs[6]  = '{1, 1'b1, 8'h0F, 8'h77, 8'h3C, 1'b0, 2};
        vecs[7]  = '{1, 1'b0, 8'h0F, 8'h00, 8'h77, 1'b0, 4};
        vecs[8]  = '{0, 1'b1, 8'h10, 8'h99, 8'h77, 1'b1, 1};
        vecs[9]  = '{2, 1'b0, 8'hF0, 8'h00, 8'h77, 1'b1, 1};
        vecs[10] = '{2, 1'b0, 8'h06, 8'h00, 8'h66, 1'b0, 4};

        rst_n     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_done",      32'(done),      32'h0);
        chk("rst_err",       32'(err),       32'h0);
        chk("rst_rdata",     32'(rdata),     32'h0);
        chk("rst_mem_en",    32'(mem_en),    32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    lat, dv, ev, rv, en_cnt);
            chk($sformatf("v%0d_lat", i),   32'(lat),   32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_done", i),  32'(dv),    32'(3'b001 << vecs[i].r));
            chk($sformatf("v%0d_err", i),   32'(ev),    32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rdata", i), 32'(rv),    32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_en", i),    32'(en_cnt), vecs[i].exp_err ? 32'd0 : 32'd1);
        end

        // Reset asserted while a read sits in WAIT.
        req_we[1]          = 1'b0;
        req_addr[1*AW +: AW] = 8'h05;
        req                = 3'b010;
        @(negedge clk);
        chk("mid_rst_access_en", 32'(mem_en), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("mid_rst_done",      32'(done),      32'h0);
        chk("mid_rst_err",       32'(err),       32'h0);
        chk("mid_rst_rdata",     32'(rdata),     32'h0);
        chk("mid_rst_mem_en",    32'(mem_en),    32'h0);
        chk("mid_rst_mem_we",    32'(mem_we),    32'h0);
        chk("mid_rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_no_done_%0d", c), 32'(done), 32'h0);
        end
        rst_n = 1'b1;
        run_txn(0, 1'b0, 8'h05, 8'h00, lat, dv, ev, rv, en_cnt);
        chk("post_rst_lat",   32'(lat), 32'd4);
        chk("post_rst_done",  32'(dv),  32'h1);
        chk("post_rst_rdata", 32'(rv),  32'hA5);
        chk("post_rst_err",   32'(ev),  32'h0);

        // All three requesters hold req high; fresh reset so requester 0 leads.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_we    = 3'b111;
        req_addr  = {8'h03, 8'h02, 8'h01};
        req_wdata = {8'h33, 8'h22, 8'h11};
        req       = 3'b111;
        grants    = 0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            @(negedge clk);
            if (done != '0) begin
                chk($sformatf("rr_onehot_%0d", grants), 32'($onehot(done)), 32'h1);
                g_idx[grants] = 0;
                for (int i = 0; i < NR; i++) if (done[i]) g_idx[grants] = i;
                grants++;
            end
        end
        req = '0;
        @(negedge clk);
        chk("rr_grant_count", 32'(grants), 32'd6);
        for (int g = 0; g < 6; g++) begin
`ifdef SHARED_RAM_ARB_FIXED_PRIO_EN
            chk($sformatf("rr_order_%0d", g), 32'(g_idx[g]), 32'd0);
`else
            chk($sformatf("rr_order_%0d", g), 32'(g_idx[g]), 32'(g % 3));
`endif
        end

        // Requester 2 changes its address while its read is in flight.
        req_we[2]            = 1'b0;
        req_addr[2*AW +: AW] = 8'h05;
        req                  = 3'b100;
        dlat = -1;
        for (int c = 1; c <= 12 && dlat < 0; c++) begin
            @(negedge clk);
            chk($sformatf("churn_mem_addr_c%0d", c), 32'(mem_addr), 32'h05);
            if (done != '0) begin
                dlat = c;
                chk("churn_done",  32'(done),  32'h4);
                chk("churn_rdata", 32'(rdata), 32'hA5);
                chk("churn_err",   32'(err),   32'h0);
                req = '0;
            end else begin
                req_addr[2*AW +: AW] = (c % 2 == 1) ? 8'h06 : 8'h25;
            end
        end
        chk("churn_lat", 32'(dlat), 32'd4);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Arbitrates a single-port shared RAM between `NUM_REQ` requesters (CPU, I/O, peripherals) using a round-robin, one-transaction-at-a-time FSM. Each requester uses a level-request / pulse-done handshake. The arbiter range-checks the address against the RAM region (upper address nibble = 4'h0, the same map used by the system address decoder). It drives the RAM port with registered signals and returns read data and error status to the granted requester.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_W`, 8: address width. Region field is `addr[ADDR_W-1:ADDR_W-4]`.
- `DATA_W`, 8: data width.
- `RD_LATENCY`, 1: cycles from the `mem_en` cycle until `mem_rdata` is valid (1..15).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  per-requester request level.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `done`  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = access outside the RAM region.
- `rdata`  out  DATA_W  read data; valid with `done` on reads, otherwise holds its last value.
- `mem_en`, `mem_we`  out  1  RAM strobe and write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data.

## Operation
- FSM states:
  - IDLE: sample `req`. If nonzero, select a winner and latch its we/addr/wdata. Go to ACCESS if in-region, else RESP with `err`=1.
  - ACCESS: `mem_en`=1 for exactly one cycle (`mem_we` = latched we). A write goes to RESP; a read loads the counter with `RD_LATENCY` and goes to WAIT.
  - WAIT: decrement the counter. At 1, capture `mem_rdata` into `rdata` and go to RESP.
  - RESP: `done[winner]`=1 and `err` driven, then IDLE.
- Round-robin:
  - Pointer `last` holds the index of the most recent winner.
  - The search starts at `last+1` and wraps modulo `NUM_REQ`.
  - `last` updates on every grant, including error grants.
- `req` is sampled only in IDLE. Changes to `req`, addr, or data during ACCESS/WAIT/RESP are ignored; a transaction is never aborted.
- The requester must drop `req` (or present its next request) at the edge where it samples `done`=1. `req` still high in the following IDLE cycle is treated as a new transaction.
- `mem_addr` and `mem_wdata` hold their latched values outside ACCESS. `mem_we`=0 whenever `mem_en`=0.
- `err` is 0 whenever `done` is 0.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `last`=`NUM_REQ-1` (requester 0 wins first), and all outputs 0 (`done`, `err`, `rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`). An in-flight transaction is dropped with no `done`.
- Cycle 0 is the IDLE cycle in which `req` is sampled high.
  - Read: `mem_en` in cycle 1; `mem_rdata` sampled at the end of cycle `1+RD_LATENCY`; `done` and `rdata` in cycle `2+RD_LATENCY`.
  - Write: `mem_en`/`mem_we` in cycle 1, `done` in cycle 2.
  - Out-of-region: `done` and `err` in cycle 1, with no `mem_en`.
- Back-to-back throughput: one read per `RD_LATENCY+3` cycles, one write per 3 cycles.
- Simultaneous requests: exactly one winner; the losers wait with `req` held. No requester waits more than `NUM_REQ-1` grants.

## Configuration
- `SHARED_RAM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `last` is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: assert `rst_n`=0 mid-read (during WAIT) -> all outputs 0 immediately, no `done`. After release, `req`=3'b001 -> requester 0 is served normally.
- Single read: RAM[0x05]=0xA5, `RD_LATENCY`=2, `req`=3'b010 with addr 0x05 -> `mem_en` in cycle 1, `done`=3'b010 with `rdata`=0xA5 and `err`=0 in cycle 4.
- Write then read: requester 0 writes 0x3C to 0x0A (`done` in cycle 2), then reads 0x0A -> `rdata`=0x3C.
- Round-robin fairness: `req`=3'b111 held, each requester re-requesting immediately -> grant order 0,1,2,0,1,2. With the macro defined -> 0,0,0.
- Out-of-region: read of 0x25 -> `done` and `err`=1 in cycle 1, `mem_en` stays 0, `rdata` unchanged.
- Request churn: requester 2 toggles its addr during WAIT -> the RAM access and `rdata` use the address latched in IDLE.
